// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit CPU register bank.
// Used by reg_file_8x4 and rf_read_port (the REG_FILE_BYPASS_EN build changes no types here).
package cpu_pkg;

  localparam int REG_W  = 4;
  localparam int REG_N  = 8;
  localparam int REG_AW = 3;

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [REG_AW-1:0] regaddr_t;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Index of the last register, where a clear sequence ends.
  localparam regaddr_t RF_LAST = regaddr_t'(REG_N - 1);

endpackage

// File: rtl/rf_read_port.sv
// Registered 8:1 read selector for one port of the register bank.
// With REG_FILE_BYPASS_EN defined, an accepted same-edge write to the read address is forwarded.
module rf_read_port
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_N*REG_W-1:0] bank_i,
  input  regaddr_t               raddr_i,
`ifdef REG_FILE_BYPASS_EN
  input  logic                   wr_en_i,
  input  regaddr_t               waddr_i,
  input  reg_t                   wdata_i,
`endif
  output reg_t                   rdata_o
);

  reg_t rdata_d;
  reg_t rdata_q;

  // Select the addressed register from the pre-edge bank contents.
  always_comb begin
    rdata_d = bank_i[raddr_i*REG_W +: REG_W];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_i && (waddr_i == raddr_i)) begin
      rdata_d = wdata_i;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/reg_file_8x4.sv
// Eight-entry by 4-bit register bank: one write port, two registered read ports, sequenced clear.
// Optional macro REG_FILE_BYPASS_EN enables write-to-read forwarding on both read ports.
module reg_file_8x4
  import cpu_pkg::*;
#(
  parameter int NREG = REG_N,
  parameter int W    = REG_W,
  parameter int AW   = REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [W-1:0]      wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [W-1:0]      rdata_a,
  output logic [W-1:0]      rdata_b,
  input  logic              clr_req,
  output logic              busy,
  output logic [NREG*W-1:0] regs_flat
);

  rf_state_t state_q, state_d;
  regaddr_t  ptr_q, ptr_d;
  reg_t      regs_q [REG_N];
  reg_t      regs_d [REG_N];
  logic      wr_accept;

  assign wr_accept = we && (state_q == RF_IDLE);
  assign busy      = (state_q == RF_CLEAR);

  // Clear walks ptr 0..7 one register per cycle; ptr wraps back to 0 on exit.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == RF_LAST) begin
          state_d = RF_IDLE;
        end
      end
      default: begin
        state_d = RF_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Writes are only accepted in IDLE, so they can never collide with a clear.
  always_comb begin
    for (int i = 0; i < REG_N; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_accept) begin
      regs_d[waddr] = wdata;
    end
    if (state_q == RF_CLEAR) begin
      regs_d[ptr_q] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < REG_N; g++) begin : g_flat
    assign regs_flat[g*REG_W +: REG_W] = regs_q[g];
  end

  rf_read_port u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .bank_i  (regs_flat),
    .raddr_i (raddr_a),
`ifdef REG_FILE_BYPASS_EN
    .wr_en_i (wr_accept),
    .waddr_i (waddr),
    .wdata_i (wdata),
`endif
    .rdata_o (rdata_a)
  );

  rf_read_port u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .bank_i  (regs_flat),
    .raddr_i (raddr_b),
`ifdef REG_FILE_BYPASS_EN
    .wr_en_i (wr_accept),
    .waddr_i (waddr),
    .wdata_i (wdata),
`endif
    .rdata_o (rdata_b)
  );

endmodule

// File: tb/tb_reg_file_8x4.sv
// Directed self-checking bench for reg_file_8x4 (honours REG_FILE_BYPASS_EN for the forwarding case).
module tb_reg_file_8x4;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [3:0]  wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [3:0]  rdata_a;
  logic [3:0]  rdata_b;
  logic        clr_req;
  logic        busy;
  logic [31:0] regs_flat;

  int errorCount = 0;
  int checkCount = 0;

  reg_file_8x4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .clr_req   (clr_req),
    .busy      (busy),
    .regs_flat (regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs, then samples 1 ns after the edge.
  task automatic applyStimulus(input logic weIn, input logic [2:0] wa, input logic [3:0] wd,
                               input logic [2:0] ra, input logic [2:0] rb, input logic clr);
    we      = weIn;
    waddr   = wa;
    wdata   = wd;
    raddr_a = ra;
    raddr_b = rb;
    clr_req = clr;
    stepClock();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] expFlat;
    logic [3:0]  expFwd;
    int          busyCycles;

    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
    #12;
    checkOutput("reset_flat", regs_flat, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_rda", {28'b0, rdata_a}, 32'h0);
    checkOutput("reset_rdb", {28'b0, rdata_b}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stepClock();

    // Idle reads of every address on both ports.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, 4'h0, 3'(i), 3'(7 - i), 1'b0);
      checkOutput($sformatf("idle_rda_%0d", i), {28'b0, rdata_a}, 32'h0);
      checkOutput($sformatf("idle_rdb_%0d", i), {28'b0, rdata_b}, 32'h0);
    end
    checkOutput("idle_flat", regs_flat, 32'h0);
    checkOutput("idle_busy", {31'b0, busy}, 32'h0);

    // Write and read back.
    applyStimulus(1'b1, 3'd3, 4'hA, 3'd0, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd7, 4'h5, 3'd0, 3'd0, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd3, 3'd7, 1'b0);
    checkOutput("wr_rda", {28'b0, rdata_a}, 32'hA);
    checkOutput("wr_rdb", {28'b0, rdata_b}, 32'h5);
    checkOutput("wr_flat3", {28'b0, regs_flat[15:12]}, 32'hA);
    checkOutput("wr_flat7", {28'b0, regs_flat[31:28]}, 32'h5);
    checkOutput("wr_flat", regs_flat, 32'h5000_A000);

    // Same-edge write and read of reg2.
    applyStimulus(1'b1, 3'd2, 4'h1, 3'd0, 3'd0, 1'b0);
`ifdef REG_FILE_BYPASS_EN
    expFwd = 4'hC;
`else
    expFwd = 4'h1;
`endif
    applyStimulus(1'b1, 3'd2, 4'hC, 3'd2, 3'd2, 1'b0);
    checkOutput("fwd_rda", {28'b0, rdata_a}, {28'b0, expFwd});
    checkOutput("fwd_rdb", {28'b0, rdata_b}, {28'b0, expFwd});
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd2, 3'd3, 1'b0);
    checkOutput("fwd_next_rda", {28'b0, rdata_a}, 32'hC);
    checkOutput("fwd_next_rdb", {28'b0, rdata_b}, 32'hA);

    // Fill 0x1..0x8 then run a clear with clr_req held and a write mid-clear.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 4'(i + 1), 3'd0, 3'd0, 1'b0);
    end
    checkOutput("fill_flat", regs_flat, 32'h8765_4321);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      expFlat = '0;
      for (int j = c; j < 8; j++) begin
        expFlat[j*4 +: 4] = 4'(j + 1);
      end
      checkOutput($sformatf("clr_busy_%0d", c), {31'b0, busy}, 32'h1);
      checkOutput($sformatf("clr_flat_%0d", c), regs_flat, expFlat);
      if (c == 3) begin
        applyStimulus(1'b1, 3'd0, 4'hF, 3'd4, 3'd1, 1'b1);
      end else begin
        applyStimulus(1'b0, 3'd0, 4'h0, 3'd4, 3'd1, (c < 7));
      end
    end
    checkOutput("clr_end_busy", {31'b0, busy}, 32'h0);
    checkOutput("clr_end_flat", regs_flat, 32'h0);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b0);
    checkOutput("clr_norestart_busy", {31'b0, busy}, 32'h0);

    // Simultaneous write and clear request in IDLE.
    applyStimulus(1'b1, 3'd5, 4'h9, 3'd5, 3'd5, 1'b1);
    checkOutput("sim_busy", {31'b0, busy}, 32'h1);
    checkOutput("sim_reg5", {28'b0, regs_flat[23:20]}, 32'h9);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 3'd0, 4'h0, 3'd5, 3'd5, 1'b0);
    end
    checkOutput("sim_reg5_held", {28'b0, regs_flat[23:20]}, 32'h9);
    checkOutput("sim_rda_held", {28'b0, rdata_a}, 32'h9);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd5, 3'd5, 1'b0);
    checkOutput("sim_reg5_cleared", {28'b0, regs_flat[23:20]}, 32'h0);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd5, 3'd5, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd5, 3'd5, 1'b0);
    checkOutput("sim_end_busy", {31'b0, busy}, 32'h0);
    checkOutput("sim_end_flat", regs_flat, 32'h0);

    // Reset in the middle of a clear.
    applyStimulus(1'b1, 3'd6, 4'h6, 3'd6, 3'd1, 1'b0);
    applyStimulus(1'b1, 3'd1, 4'h3, 3'd6, 3'd1, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd6, 3'd1, 1'b1);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd6, 3'd1, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd6, 3'd1, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd6, 3'd1, 1'b0);
    checkOutput("mid_busy", {31'b0, busy}, 32'h1);
    checkOutput("mid_flat", regs_flat, 32'h0600_0000);
    checkOutput("mid_rda", {28'b0, rdata_a}, 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {31'b0, busy}, 32'h0);
    checkOutput("arst_flat", regs_flat, 32'h0);
    checkOutput("arst_rda", {28'b0, rdata_a}, 32'h0);
    checkOutput("arst_rdb", {28'b0, rdata_b}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stepClock();
    checkOutput("post_rst_busy", {31'b0, busy}, 32'h0);

    // Fresh clear after reset must run the full eight cycles.
    applyStimulus(1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b1);
    busyCycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busyCycles++;
      applyStimulus(1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b0);
    end
    checkOutput("post_rst_clr_len", 32'(busyCycles), 32'd8);
    checkOutput("post_rst_final_busy", {31'b0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
